// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential set-less-than unit.
//   state_t                      : compare FSM encoding (IDLE / BUSY / DONE)
//   SLT_TRUE / SLT_FALSE         : single-bit result values
//   DEFAULT_WIDTH/DEFAULT_DIGIT  : default operand width and bits resolved per cycle
// No ports; imported by slt_digit_cmp and slt_seq_cmp.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SLT_TRUE  = 1'b1;
    localparam logic SLT_FALSE = 1'b0;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIGIT = 4;

endpackage

// File: rtl/slt_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
// Ports:
//   a, b : [DIGIT-1:0] operand digits
//   lt   : a < b (unsigned)
//   neq  : a != b
module slt_digit_cmp
    import alu_pkg::*;
#(
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             neq
);

    assign lt  = (a < b);
    assign neq = (a != b);

endmodule

// File: rtl/slt_seq_cmp.sv
// Multi-cycle set-less-than (SLT / SLTU) unit, DIGIT bits resolved per clock,
// most significant digit first.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_VALID / IN_READY : operand handshake (RS, RT, UNS)
//   RS, RT [WIDTH]      : operands
//   UNS                 : 1 = unsigned compare, 0 = signed compare
//   OUT_VALID/OUT_READY : result handshake
//   LT_O [WIDTH]        : WIDTH'(1) when RS < RT, else 0
//   EQ_O                : RS == RT
// Build option: define SLT_EARLY_EXIT_EN to leave BUSY as soon as the first
// differing digit is found; results are identical, only latency changes.
module slt_seq_cmp
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    input  logic             UNS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] LT_O,
    output logic             EQ_O
);

    localparam int NUM_STEPS = WIDTH / DIGIT;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
            $error("slt_seq_cmp: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t            state_reg,    state_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;
    logic [WIDTH-1:0]  rs_reg,       rs_next;
    logic [WIDTH-1:0]  rt_reg,       rt_next;
    logic              lt_reg,       lt_next;
    logic              decided_reg,  decided_next;
    logic              in_ready_reg, in_ready_next;

    // Digit views of the latched operands; the single comparator picks one by cnt.
    logic [DIGIT-1:0] rs_dig [NUM_STEPS];
    logic [DIGIT-1:0] rt_dig [NUM_STEPS];
    logic [DIGIT-1:0] cur_rs, cur_rt;
    logic             dig_lt, dig_neq;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STEPS; gi++) begin : g_dig
            assign rs_dig[gi] = rs_reg[gi*DIGIT +: DIGIT];
            assign rt_dig[gi] = rt_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign cur_rs = rs_dig[cnt_reg];
    assign cur_rt = rt_dig[cnt_reg];

    slt_digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a   (cur_rs),
        .b   (cur_rt),
        .lt  (dig_lt),
        .neq (dig_neq)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rs_reg       <= '0;
            rt_reg       <= '0;
            lt_reg       <= SLT_FALSE;
            decided_reg  <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rs_reg       <= rs_next;
            rt_reg       <= rt_next;
            lt_reg       <= lt_next;
            decided_reg  <= decided_next;
            in_ready_reg <= in_ready_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rs_next      = rs_reg;
        rt_next      = rt_reg;
        lt_next      = lt_reg;
        decided_next = decided_reg;

        case (state_reg)
            IDLE: begin
                // in_ready_reg gates acceptance so the unit stays closed for
                // the first cycle out of reset.
                if (IN_VALID && in_ready_reg) begin
                    rs_next      = UNS ? RS : (RS ^ SIGN_FLIP);
                    rt_next      = UNS ? RT : (RT ^ SIGN_FLIP);
                    cnt_next     = CNT_W'(NUM_STEPS - 1);
                    lt_next      = SLT_FALSE;
                    decided_next = 1'b0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                // The first differing digit from the top fixes the result.
                if (!decided_reg && dig_neq) begin
                    lt_next      = dig_lt ? SLT_TRUE : SLT_FALSE;
                    decided_next = 1'b1;
                end
`ifdef SLT_EARLY_EXIT_EN
                if (cnt_reg == '0 || (!decided_reg && dig_neq)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
`else
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
`endif
            end
            DONE: begin
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        in_ready_next = (state_next == IDLE);
    end

    assign IN_READY  = in_ready_reg;
    assign OUT_VALID = (state_reg == DONE);
    assign LT_O      = {{(WIDTH-1){1'b0}}, OUT_VALID & lt_reg};
    assign EQ_O      = OUT_VALID & ~decided_reg;

endmodule

// File: doc/slt_seq_cmp.md
Name: slt_seq_cmp

Overview:
Parametrised, multi-cycle set-less-than unit for the MIPS ALU datapath. It generalises the 16-bit ripple SLT to any WIDTH, supports both signed (SLT) and unsigned (SLTU) compares, and resolves DIGIT bits per clock, MSB-first. Operands enter through a valid/ready handshake, and the result leaves through a separate valid/ready handshake. The execute stage stalls on it.

Parameters:
WIDTH, 16, operand and result width in bits; must be at least 2.
DIGIT, 4, bits compared per cycle; must divide WIDTH exactly (elaboration error otherwise).
NUM_STEPS, WIDTH/DIGIT, derived local constant; not overridable.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  reset, asynchronous, active-low.
IN_VALID  input  1  RS/RT/UNS are valid this cycle.
IN_READY  output  1  unit can accept an operand pair.
RS  input  WIDTH  first operand.
RT  input  WIDTH  second operand.
UNS  input  1  1 = unsigned compare (SLTU), 0 = signed compare (SLT).
OUT_VALID  output  1  LT_O/EQ_O hold a result.
OUT_READY  input  1  consumer takes the result.
LT_O  output  WIDTH  WIDTH'(1) if RS < RT under the selected mode, else 0.
EQ_O  output  1  1 if RS == RT.

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE; IN_READY = 0; OUT_VALID = 0; LT_O = 0; EQ_O = 0; step counter and operand registers = 0. IN_READY rises on the first CLK edge after RST_N deasserts.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - IN_READY = 1.
  - On IN_VALID & IN_READY: latch RS and RT. When UNS = 0, invert the MSB of both latched operands, so the signed compare becomes an unsigned compare.
  - Set cnt = NUM_STEPS-1 and decided = 0, then go to BUSY. IN_READY drops in the same edge.
- BUSY:
  - IN_READY = 0.
  - Each cycle, compare digit cnt, i.e. bits [cnt*DIGIT+DIGIT-1 : cnt*DIGIT].
  - If decided = 0 and the RS digit differs from the RT digit: set lt = (RS digit < RT digit) and decided = 1. Later digits never change lt once decided = 1.
  - If cnt == 0, go to DONE; otherwise decrement cnt.
- DONE:
  - OUT_VALID = 1; LT_O = {WIDTH-1 zeros, lt}; EQ_O = ~decided.
  - Outputs hold stable while OUT_READY = 0.
  - On OUT_READY: OUT_VALID drops and the state returns to IDLE (IN_READY = 1 the next cycle).
- Latency: the acceptance edge is followed by exactly NUM_STEPS BUSY cycles (4 at default parameters). OUT_VALID is high in the cycle after the NUM_STEPS-th BUSY edge.
- Throughput: one operation per NUM_STEPS+2 cycles minimum. There is no overlap.
- OUT_READY held high before DONE: has no effect until DONE; the result is then consumed in its first DONE cycle.
- IN_VALID outside IDLE: ignored. The producer must hold its data until it sees IN_READY.
- Equal operands: lt = 0, EQ_O = 1.
- Extremes: the most negative versus the most positive value must be correct in signed mode, and reversed in unsigned mode.
- Reset mid-operation (BUSY or DONE): the result is discarded and all outputs return to their reset values immediately.

Optional Feature:
SLT_EARLY_EXIT_EN.
- Defined: BUSY moves to DONE in the same edge where decided becomes 1, so latency = (number of leading equal digits)+1 cycles. Equal operands still take NUM_STEPS cycles.
- Undefined: fixed latency of NUM_STEPS cycles as specified above.
- The value of LT_O/EQ_O is identical in both builds.

Decomposition:
- Shared package (alu_pkg) holds:
  - the FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - SLT_TRUE / SLT_FALSE result constants;
  - the default WIDTH/DIGIT constants.
- One sub-module, slt_digit_cmp: combinational DIGIT-bit compare, outputs lt and neq. It is instantiated once and indexed by cnt.

Test Plan:
1. Unsigned: WIDTH = 16, DIGIT = 4, UNS = 1, RS = 16'h0003, RT = 16'h8000, OUT_READY = 1 -> OUT_VALID exactly 4 cycles after acceptance; LT_O = 16'h0001; EQ_O = 0.
2. Signed vs unsigned: UNS = 0 with the same operands (3 < -32768 is false) -> LT_O = 16'h0000. Then UNS = 0, RS = 16'h8000, RT = 16'h7FFF -> LT_O = 16'h0001.
3. Equality and backpressure: RS = RT = 16'hA5A5 -> LT_O = 0, EQ_O = 1. Holding OUT_READY = 0 for 5 cycles -> OUT_VALID and outputs stay stable; IN_READY stays 0.
4. Early exit: with SLT_EARLY_EXIT_EN defined, RS = 16'h1000, RT = 16'h2000 -> OUT_VALID 1 cycle after acceptance, LT_O = 1. Without the macro -> 4 cycles, same result.
5. Reset mid-operation: assert RST_N = 0 two cycles into BUSY -> all outputs 0 asynchronously. After release, IN_READY returns 1 one edge later, and a new compare RS = 5, RT = 6 gives LT_O = 1.
6. Parameter sweep: WIDTH = 32, DIGIT = 8 and WIDTH = 8, DIGIT = 1, with 1000 random RS/RT/UNS each -> matches the $signed/$unsigned reference model; fixed latency = WIDTH/DIGIT.
